// File: rtl/hex_sched_pkg.sv
// Shared types and helpers for the hex display scheduler.
//   state_t    : scheduler FSM states (IDLE, SHOW, OVR)
//   HEX_BLANK  : value driven to the display when nothing is shown
//   calc_src_w : width of a source index, never less than one bit
package hex_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    OVR
  } state_t;

  localparam logic [15:0] HEX_BLANK = 16'h0000;

  function automatic int calc_src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_display_sched_rr_next_valid.sv
// Round-robin search over a valid vector.
//   valid     : per-source valid bits
//   start     : search origin; the result lies strictly after it, wrapping
//   next_idx  : first valid index after start (start itself if none)
//   any_valid : high when at least one bit of valid is set
// An "at or after X" search is obtained by passing start = X-1 mod NUM_SRC.
module rr_next_valid
  import hex_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = calc_src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SRC_W-1:0]   start,
  output logic [SRC_W-1:0]   next_idx,
  output logic               any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid hit wins.
  always_comb begin
    next_idx  = start;
    any_valid = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (valid[(int'(start) + k) % NUM_SRC]) begin
        next_idx  = SRC_W'((int'(start) + k) % NUM_SRC);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_display_sched.sv
// Shares one four-digit hex display between NUM_SRC 16-bit status sources.
//   clk, reset  : clock and asynchronous active-high reset
//   src_data    : packed sources, source i at bits [16*i+15:16*i]
//   src_valid   : per-source valid; invalid sources are skipped
//   auto_en     : 1 = timed round-robin, 0 = manual selection by page_sel
//   page_sel    : manual source index
//   ovr_req     : override request (level)
//   ovr_data    : override value, latched when the request is accepted
//   ovr_ack     : one-cycle pulse marking an accepted override
//   hex_data    : registered display value
//   cur_src     : index of the source currently selected
//   ovr_active  : high while the override value is displayed
module hex_display_sched
  import hex_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int HOLD_CYCLES  = 100000000,
  parameter int SRC_W        = calc_src_w(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic                   auto_en,
  input  logic [SRC_W-1:0]       page_sel,
  input  logic                   ovr_req,
  input  logic [15:0]            ovr_data,
  output logic                   ovr_ack,
  output logic [15:0]            hex_data,
  output logic [SRC_W-1:0]       cur_src,
  output logic                   ovr_active
);

  localparam int CNT_MAX = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(NUM_SRC - 1);

  state_t           state, state_nxt;
  logic [SRC_W-1:0] cur_src_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [15:0]      ovr_val, ovr_val_nxt;
  logic [15:0]      hex_nxt;
  logic             ack_nxt;

  logic [SRC_W-1:0] cur_prev, rr_start, rr_next;
  logic             any_valid;
  logic             page_in_range, page_ok;
  state_t           idle_state;
  logic [SRC_W-1:0] idle_src;

  // With a power-of-two source count every page_sel value is a real source.
  if ((1 << SRC_W) == NUM_SRC) begin : g_page_full
    assign page_in_range = 1'b1;
  end else begin : g_page_part
    assign page_in_range = (page_sel <= LAST_IDX);
  end

  assign page_ok  = page_in_range && src_valid[page_sel];
  assign cur_prev = (cur_src == '0) ? LAST_IDX : cur_src - 1'b1;

  // In SHOW we need the source strictly after cur_src; everywhere else the
  // lowest valid source at or after it. When cur_src has just gone invalid
  // the two searches coincide, so SHOW can reuse the strictly-after result.
  assign rr_start = (state == SHOW) ? cur_src : cur_prev;

  rr_next_valid #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr (
    .valid     (src_valid),
    .start     (rr_start),
    .next_idx  (rr_next),
    .any_valid (any_valid)
  );

  // Where the display settles when (re)entering from no source, from a lost
  // source, on any manual-mode cycle or when an override expires.
  always_comb begin
    idle_state = IDLE;
    idle_src   = cur_src;
    if (auto_en) begin
      if (any_valid) begin
        idle_state = SHOW;
        idle_src   = rr_next;
      end
    end else if (page_ok) begin
      idle_state = SHOW;
      idle_src   = page_sel;
    end
  end

  // Next-state logic. An override request beats everything, including a
  // dwell expiry on the same cycle, so cur_src does not advance then.
  always_comb begin
    state_nxt   = state;
    cur_src_nxt = cur_src;
    dwell_nxt   = dwell_cnt;
    hold_nxt    = hold_cnt;
    ovr_val_nxt = ovr_val;
    ack_nxt     = 1'b0;

    if (ovr_req) begin
      state_nxt   = OVR;
      ovr_val_nxt = ovr_data;
      ack_nxt     = 1'b1;
      hold_nxt    = '0;
      dwell_nxt   = '0;
      if (state == OVR && !auto_en && page_in_range) begin
        cur_src_nxt = page_sel;
      end
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = idle_state;
          cur_src_nxt = idle_src;
          dwell_nxt   = '0;
        end
        SHOW: begin
          if (!auto_en || !src_valid[cur_src]) begin
            state_nxt   = idle_state;
            cur_src_nxt = idle_src;
            dwell_nxt   = '0;
          end else if (dwell_cnt == DWELL_LAST) begin
            cur_src_nxt = rr_next;
            dwell_nxt   = '0;
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
        OVR: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt   = idle_state;
            cur_src_nxt = idle_src;
            hold_nxt    = '0;
            dwell_nxt   = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
            if (!auto_en && page_in_range) begin
              cur_src_nxt = page_sel;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Display value is chosen from the next state so the register output
  // tracks the live source with a single cycle of latency.
  always_comb begin
    hex_nxt = HEX_BLANK;
    case (state_nxt)
      SHOW:    hex_nxt = src_data[{cur_src_nxt, 4'b0000} +: 16];
      OVR:     hex_nxt = ovr_val_nxt;
      default: hex_nxt = HEX_BLANK;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_src   <= '0;
      dwell_cnt <= '0;
      hold_cnt  <= '0;
      ovr_val   <= HEX_BLANK;
      ovr_ack   <= 1'b0;
      hex_data  <= HEX_BLANK;
    end else begin
      state     <= state_nxt;
      cur_src   <= cur_src_nxt;
      dwell_cnt <= dwell_nxt;
      hold_cnt  <= hold_nxt;
      ovr_val   <= ovr_val_nxt;
      ovr_ack   <= ack_nxt;
      hex_data  <= hex_nxt;
    end
  end

  assign ovr_active = (state == OVR);

endmodule

// File: doc/hex_display_sched.md
Name: hex_display_sched

Overview:
Scheduler that shares the board's single 16-bit, four-digit seven-segment display path between several 16-bit status sources. It sits directly upstream of the hex driver, whose hex_data input it feeds.
- Auto mode: rotates round-robin through valid sources, each shown for a fixed dwell time.
- Manual mode: a selected source is shown.
- Override: a one-shot message channel pre-empts either mode for a fixed hold time, then display resumes.

Parameters:
NUM_SRC, 4, number of display sources (2..16)
DWELL_CYCLES, 50000000, clk cycles each source is shown in auto mode (>=2)
HOLD_CYCLES, 100000000, clk cycles an override value is shown (>=2)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
src_data  in  16*NUM_SRC  source i occupies bits [16*i+15:16*i]
src_valid  in  NUM_SRC  per-source valid; invalid sources are skipped
auto_en  in  1  1 = round-robin rotation, 0 = manual selection
page_sel  in  SRC_W  manual source index; SRC_W = max(1, clog2(NUM_SRC))
ovr_req  in  1  override request (level)
ovr_data  in  16  override value, sampled on acceptance
ovr_ack  out  1  one-cycle pulse: override accepted
hex_data  out  16  value to display, registered
cur_src  out  SRC_W  source index currently shown (held during override)
ovr_active  out  1  high while override value is displayed

Behaviour:
- Reset values: hex_data=16'h0000, cur_src=0, ovr_active=0, ovr_ack=0, dwell counter=0, state=IDLE. Reset may assert at any time, including mid-dwell or mid-override; the override is abandoned and not acked.
- States:
  - IDLE: no displayable source; hex_data=0000.
  - SHOW: source cur_src is displayed.
  - OVR: override is displayed.
- Output timing: hex_data is registered. In SHOW it follows src_data[cur_src] with 1-cycle latency, so live source updates are reflected.
- Auto mode (auto_en=1):
  - IDLE -> SHOW when any src_valid is set. cur_src = lowest valid index at or after the current cur_src.
  - In SHOW, the dwell counter increments each cycle. At DWELL_CYCLES-1 it clears, and cur_src advances to the next valid index above cur_src, wrapping modulo NUM_SRC.
  - If cur_src is the only valid source, it stays and the counter clears.
  - If src_valid[cur_src] drops, cur_src advances to the next valid source on the next cycle with the counter cleared. If no source is valid, go to IDLE.
- Manual mode (auto_en=0):
  - The dwell counter is held at 0.
  - cur_src = page_sel when page_sel < NUM_SRC and src_valid[page_sel]=1: SHOW.
  - Otherwise IDLE, with cur_src holding its last value.
  - An auto_en toggle takes effect the next cycle; the counter restarts from 0.
- Override:
  - Accepted in IDLE or SHOW when ovr_req=1: ovr_data is latched, ovr_ack pulses for one cycle, and the FSM enters OVR.
  - OVR lasts HOLD_CYCLES cycles with ovr_active=1 and hex_data=latched value.
  - On exit, the FSM re-evaluates mode/valid exactly as from IDLE, and the dwell counter is 0.
  - ovr_req asserted during OVR is re-accepted: ack, relatch, hold restarts.
  - A requester holding ovr_req high continuously is re-accepted every cycle. Requesters must drop ovr_req on ovr_ack.
  - Simultaneous ovr_req and dwell expiry: the override wins. cur_src does not advance; the dwell counter clears.
- Source changes during OVR are not displayed. cur_src tracks manual page_sel but does not rotate.
- Width rules:
  - Dwell and hold counters are sized clog2(max(DWELL_CYCLES, HOLD_CYCLES)) and never wrap past their terminal count.
  - Index arithmetic is modulo NUM_SRC, correct for non-power-of-two NUM_SRC.

Decomposition:
- Package hex_sched_pkg:
  - state enum {IDLE, SHOW, OVR};
  - HEX_BLANK = 16'h0000;
  - the SRC_W computation function.
- One combinational sub-module, rr_next_valid: inputs valid vector and start index, outputs next valid index (strictly after start, wrapping) and an any_valid flag. The same sub-module also serves the "at or after" search by passing start-1 mod NUM_SRC.

Test Plan:
(All with NUM_SRC=4, DWELL_CYCLES=4, HOLD_CYCLES=3, src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111}.)
1. Reset mid-run, then valid=4'b1111, auto_en=1 -> hex_data=0000 during reset. Afterwards 1111, 2222, 3333, 4444, 1111, each held 4 cycles; cur_src 0,1,2,3,0.
2. valid=4'b0101 -> sequence 1111, 3333 repeating. Drop valid[2] while showing 3333 -> 1111 appears within 2 cycles. valid=0 -> hex_data=0000.
3. auto_en=0, page_sel=1 -> 2222 steady indefinitely. page_sel=3 with valid[3]=0 -> 0000.
4. In SHOW, pulse ovr_req=1 with ovr_data=BEEF -> ovr_ack high exactly 1 cycle; BEEF and ovr_active for 3 cycles; then the same source resumes with a full 4-cycle dwell.
5. ovr_req on the dwell-expiry cycle -> BEEF shown; cur_src unchanged after return. Second ovr_req (CAFE) during OVR -> second ack; CAFE shown for 3 fresh cycles.
6. Assert reset during OVR -> ovr_active=0 and hex_data=0000 immediately (async). No ack after release; rotation restarts at source 0.
